ifu_fetch: RTL and testbench

//  Instruction-fetch stage owning the architectural PC register. Issues one word fetch per

---
 rtl/ifu_fetch_pkg.sv | 27 ++
 rtl/ifu_fetch_if.sv | 30 +++
 rtl/ifu_fetch.sv | 100 ++++++++++
 tb/tb_ifu_fetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional fetch-window check (ALIGN_CHECK_EN) adds the window defaults and helper.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;

`ifdef ALIGN_CHECK_EN
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES_DEF = 32'h0000_4000;

  // 33-bit compare so a window ending at 2^32 does not wrap
  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [31:0] bytes);
    return ({1'b0, a} >= {1'b0, base}) &&
           ({1'b0, a} <  ({1'b0, base} + {1'b0, bytes}));
  endfunction
`endif

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and the decode handoff.
// master = fetch stage, slave = memory plus decode side.
interface ifu_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_exc_adel;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc, instr_exc_adel,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc, instr_exc_adel,
    output instr_ready
  );

endinterface

// File: rtl/ifu_fetch.sv
// Fetch stage owning the PC: one memory fetch per instruction, held for decode; 3 cycles minimum.
// Stalls on req_ready/rsp_valid/instr_ready; ALIGN_CHECK_EN adds an address-fault path skipping memory.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEF
`ifdef ALIGN_CHECK_EN
  , parameter logic [31:0] IM_BASE  = IM_BASE_DEF
  , parameter logic [31:0] IM_BYTES = IM_BYTES_DEF
`endif
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  npc,
  output logic [31:0]  pc,
  output logic [31:0]  fetch_count,
  ifu_fetch_if.master  bus
);

  ifu_state_e state, state_nxt;
  logic       fault;
  logic       fault_take;
  logic       rsp_fire;
  logic       hold_fire;
  logic [31:0] instr_q;

`ifdef ALIGN_CHECK_EN
  assign fault         = (pc[1:0] != 2'b00) || !in_window(pc, IM_BASE, IM_BYTES);
  assign bus.imem_addr = {pc[31:2], 2'b00};
`else
  assign fault         = 1'b0;
  assign bus.imem_addr = pc;
`endif

  assign fault_take = (state == S_REQ) && fault;
  assign rsp_fire   = (state == S_WAIT) && bus.imem_rsp_valid;
  assign hold_fire  = (state == S_HOLD) && bus.instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (fault)                   state_nxt = S_HOLD;
        else if (bus.imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: if (bus.imem_rsp_valid) state_nxt = S_HOLD;
      S_HOLD: if (bus.instr_ready)    state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req_valid = 1'b0;
    bus.instr_valid    = 1'b0;
    case (state)
      S_REQ:   bus.imem_req_valid = !fault;
      S_HOLD:  bus.instr_valid    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       pc <= RESET_PC;
    else if (hold_fire) pc <= npc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       fetch_count <= 32'd0;
    else if (hold_fire) fetch_count <= fetch_count + 32'd1;
  end

  // A faulting fetch hands decode a nop instead of touching memory
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        instr_q <= 32'd0;
    else if (rsp_fire)   instr_q <= bus.imem_rsp_data;
    else if (fault_take) instr_q <= 32'd0;
  end

`ifdef ALIGN_CHECK_EN
  logic exc_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        exc_q <= 1'b0;
    else if (rsp_fire)   exc_q <= 1'b0;
    else if (fault_take) exc_q <= 1'b1;
  end
  assign bus.instr_exc_adel = exc_q;
`else
  assign bus.instr_exc_adel = 1'b0;
`endif

  assign bus.instr    = instr_q;
  assign bus.instr_pc = pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: acts as memory and decode, checks against a transaction-level PC/count model.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] npc = 32'd0;
  logic [31:0] pc;
  logic [31:0] fetch_count;

  ifu_fetch_if bus_if();

  ifu_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .npc         (npc),
    .pc          (pc),
    .fetch_count (fetch_count),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: PC of the next instruction and instructions delivered so far
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  typedef struct {
    logic [31:0] addr, instr, ipc, pc_hold, pc_after, cnt_before, cnt_after;
    logic        exc, saw_req, addr_stable, hold_stable, timeout;
    int          lat;
  } obs_t;

  // Drives one instruction through memory and decode; starts and ends on a negedge.
  task automatic do_fetch(input int rs, input int rd, input int hs,
                          input logic [31:0] nv, input logic [31:0] dat, output obs_t o);
    int cyc;
    cyc = 0;
    o.addr = 32'd0; o.instr = 32'd0; o.ipc = 32'd0; o.pc_hold = 32'd0;
    o.pc_after = 32'd0; o.cnt_before = 32'd0; o.cnt_after = 32'd0;
    o.exc = 1'b0; o.saw_req = 1'b0; o.addr_stable = 1'b1; o.hold_stable = 1'b1;
    o.timeout = 1'b0; o.lat = 0;
    while (!bus_if.imem_req_valid && !bus_if.instr_valid && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    if (bus_if.imem_req_valid) begin
      o.saw_req = 1'b1;
      o.addr = bus_if.imem_addr;
      for (int i = 0; i < rs; i++) begin
        bus_if.imem_req_ready = 1'b0;
        @(negedge clk); cyc++;
        if (!bus_if.imem_req_valid || bus_if.imem_addr !== o.addr) o.addr_stable = 1'b0;
      end
      bus_if.imem_req_ready = 1'b1;
      @(negedge clk); cyc++;
      bus_if.imem_req_ready = 1'b0;
      for (int i = 0; i < rd; i++) begin
        bus_if.imem_rsp_data = $urandom;
        @(negedge clk); cyc++;
      end
      bus_if.imem_rsp_valid = 1'b1;
      bus_if.imem_rsp_data  = dat;
      @(negedge clk); cyc++;
      bus_if.imem_rsp_valid = 1'b0;
      bus_if.imem_rsp_data  = $urandom;
    end
    while (!bus_if.instr_valid && cyc < 40) begin
      @(negedge clk); cyc++;
    end
    o.timeout    = !bus_if.instr_valid;
    o.instr      = bus_if.instr;
    o.ipc        = bus_if.instr_pc;
    o.exc        = bus_if.instr_exc_adel;
    o.pc_hold    = pc;
    o.cnt_before = fetch_count;
    // Decode stalls while memory noise (stray rsp/ready) must be ignored
    for (int i = 0; i < hs; i++) begin
      bus_if.instr_ready    = 1'b0;
      bus_if.imem_rsp_valid = 1'b1;
      bus_if.imem_rsp_data  = $urandom;
      bus_if.imem_req_ready = 1'b1;
      npc = $urandom;
      @(negedge clk); cyc++;
      if (!bus_if.instr_valid || bus_if.imem_req_valid || bus_if.instr !== o.instr ||
          bus_if.instr_pc !== o.ipc || pc !== o.pc_hold || fetch_count !== o.cnt_before)
        o.hold_stable = 1'b0;
    end
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_req_ready = 1'b0;
    npc = nv;
    bus_if.instr_ready = 1'b1;
    @(negedge clk); cyc++;
    bus_if.instr_ready = 1'b0;
    o.lat       = cyc;
    o.cnt_after = fetch_count;
    o.pc_after  = pc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = 32'd0;
    bus_if.instr_ready    = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (bus_if.imem_req_valid !== 1'b0 || bus_if.instr_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valids req=%b instr=%b want 0 0", bus_if.imem_req_valid, bus_if.instr_valid);
    end
    total++;
    if (pc !== 32'h0000_3000 || fetch_count !== 32'd0) begin
      bad++; $display("FAIL reset_regs pc=%h cnt=%0d want 00003000 0", pc, fetch_count);
    end
    total++;
    if (bus_if.instr !== 32'd0 || bus_if.instr_exc_adel !== 1'b0) begin
      bad++; $display("FAIL reset_instr instr=%h exc=%b want 0 0", bus_if.instr, bus_if.instr_exc_adel);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (bus_if.imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL reset_dead_cycle req=%b want 0", bus_if.imem_req_valid);
    end
    @(negedge clk);
    total++;
    if (bus_if.imem_req_valid !== 1'b1 || bus_if.imem_addr !== 32'h0000_3000) begin
      bad++; $display("FAIL reset_first_req req=%b addr=%h want 1 00003000", bus_if.imem_req_valid, bus_if.imem_addr);
    end
    exp_pc = 32'h0000_3000;
    exp_count = 32'd0;
  endtask

  task automatic test_straight();
    obs_t o;
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      do_fetch(0, 0, 0, exp_pc + 32'd4, d, o);
      total++;
      if (o.addr !== exp_pc || o.ipc !== exp_pc) begin
        bad++; $display("FAIL straight_pc k=%0d addr=%h ipc=%h want %h", k, o.addr, o.ipc, exp_pc);
      end
      total++;
      if (o.instr !== d || o.lat !== 3) begin
        bad++; $display("FAIL straight_data k=%0d instr=%h lat=%0d want %h 3", k, o.instr, o.lat, d);
      end
      exp_pc = exp_pc + 32'd4;
      exp_count = exp_count + 32'd1;
    end
    total++;
    if (pc !== 32'h0000_300C || fetch_count !== 32'd3) begin
      bad++; $display("FAIL straight_end pc=%h cnt=%0d want 0000300c 3", pc, fetch_count);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    do_fetch(0, 0, 4, exp_pc + 32'd4, 32'h2408_0005, o);
    total++;
    if (!o.hold_stable || o.instr !== 32'h2408_0005 || o.ipc !== exp_pc) begin
      bad++; $display("FAIL backpressure stable=%b instr=%h ipc=%h want 1 24080005 %h", o.hold_stable, o.instr, o.ipc, exp_pc);
    end
    exp_pc = exp_pc + 32'd4;
    exp_count = exp_count + 32'd1;
    total++;
    if (o.cnt_after !== exp_count || o.lat !== 7) begin
      bad++; $display("FAIL backpressure_cnt cnt=%0d lat=%0d want %0d 7", o.cnt_after, o.lat, exp_count);
    end
  endtask

  task automatic test_mem_stall();
    obs_t o;
    logic [31:0] d;
    d = $urandom;
    do_fetch(3, 2, 0, exp_pc + 32'd4, d, o);
    total++;
    if (!o.addr_stable || o.addr !== exp_pc) begin
      bad++; $display("FAIL mem_stall_addr stable=%b addr=%h want 1 %h", o.addr_stable, o.addr, exp_pc);
    end
    total++;
    if (o.instr !== d || o.lat !== 8) begin
      bad++; $display("FAIL mem_stall_data instr=%h lat=%0d want %h 8", o.instr, o.lat, d);
    end
    exp_pc = exp_pc + 32'd4;
    exp_count = exp_count + 32'd1;
  endtask

  task automatic test_jump();
    obs_t o;
    do_fetch(0, 0, 0, 32'h0000_3400, $urandom, o);
    exp_pc = 32'h0000_3400;
    exp_count = exp_count + 32'd1;
    total++;
    if (o.pc_after !== 32'h0000_3400) begin
      bad++; $display("FAIL jump_pc pc=%h want 00003400", o.pc_after);
    end
    do_fetch(0, 0, 0, exp_pc + 32'd4, $urandom, o);
    total++;
    if (o.addr !== 32'h0000_3400 || o.ipc !== 32'h0000_3400) begin
      bad++; $display("FAIL jump_target addr=%h ipc=%h want 00003400", o.addr, o.ipc);
    end
    exp_pc = exp_pc + 32'd4;
    exp_count = exp_count + 32'd1;
  endtask

  task automatic test_random();
    obs_t o;
    int rs, rd, hs;
    logic [31:0] d, nv;
    for (int k = 0; k < 24; k++) begin
      rs = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      hs = $urandom_range(0, 2);
      d  = $urandom;
      nv = 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
      do_fetch(rs, rd, hs, nv, d, o);
      total++;
      if (o.timeout || o.addr !== exp_pc || o.ipc !== exp_pc || o.instr !== d) begin
        bad++; $display("FAIL random_xfer k=%0d to=%b addr=%h ipc=%h instr=%h want %h %h", k, o.timeout, o.addr, o.ipc, o.instr, exp_pc, d);
      end
      exp_pc = nv;
      exp_count = exp_count + 32'd1;
      total++;
      if (o.cnt_after !== exp_count || o.pc_after !== exp_pc || o.lat !== rs + rd + hs + 3) begin
        bad++; $display("FAIL random_state k=%0d cnt=%0d pc=%h lat=%0d want %0d %h %0d", k, o.cnt_after, o.pc_after, o.lat, exp_count, exp_pc, rs + rd + hs + 3);
      end
    end
  endtask

  task automatic test_align();
    obs_t o;
    logic [31:0] d;
    logic [31:0] bad_pc [2];
    bad_pc[0] = 32'h0000_3002;
    bad_pc[1] = 32'h0000_8000;
    for (int k = 0; k < 2; k++) begin
      do_fetch(0, 0, 0, bad_pc[k], $urandom, o);
      exp_pc = bad_pc[k];
      exp_count = exp_count + 32'd1;
      d = $urandom;
      do_fetch(0, 0, 0, 32'h0000_3000, d, o);
      exp_count = exp_count + 32'd1;
`ifdef ALIGN_CHECK_EN
      total++;
      if (o.saw_req !== 1'b0 || o.instr !== 32'd0 || o.exc !== 1'b1 || o.ipc !== exp_pc) begin
        bad++; $display("FAIL align_fault k=%0d req=%b instr=%h exc=%b ipc=%h want 0 0 1 %h", k, o.saw_req, o.instr, o.exc, o.ipc, exp_pc);
      end
`else
      total++;
      if (o.saw_req !== 1'b1 || o.addr !== exp_pc || o.instr !== d || o.exc !== 1'b0) begin
        bad++; $display("FAIL align_pass k=%0d req=%b addr=%h instr=%h exc=%b want 1 %h %h 0", k, o.saw_req, o.addr, o.instr, o.exc, exp_pc, d);
      end
`endif
      exp_pc = 32'h0000_3000;
      total++;
      if (o.cnt_after !== exp_count || o.pc_after !== exp_pc) begin
        bad++; $display("FAIL align_state k=%0d cnt=%0d pc=%h want %0d %h", k, o.cnt_after, o.pc_after, exp_count, exp_pc);
      end
    end
    // The stage must resume normal fetching afterwards
    d = $urandom;
    do_fetch(0, 0, 0, exp_pc + 32'd4, d, o);
    total++;
    if (o.saw_req !== 1'b1 || o.addr !== exp_pc || o.instr !== d || o.exc !== 1'b0) begin
      bad++; $display("FAIL align_recover req=%b addr=%h instr=%h exc=%b want 1 %h %h 0", o.saw_req, o.addr, o.instr, o.exc, exp_pc, d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_mem_stall();
    test_jump();
    test_random();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
